// File: rtl/fazyrv_rf_mp.sv
// Chunked register-file front-end: sequences BRAM reads into per-port operand
// shift registers, buffers result chunks into a word and forwards commits that race a read.
module fazyrv_rf_mp #(
  parameter int BWIDTH    = 1,
  parameter int NRP       = 2,
  parameter int RAM_RP    = 1,
  parameter int ADR_WIDTH = 5
) (
  input  logic                          clk_i,
  input  logic                          rst_in,
  input  logic                          rf_rstb_i,
  input  logic [5*NRP-1:0]              rf_rs_i,
  output logic                          rf_rdy_o,
  output logic                          rf_busy_o,
  input  logic                          rf_shft_i,
  output logic [BWIDTH*NRP-1:0]         rf_op_o,
  input  logic [4:0]                    rf_rd_i,
  input  logic [BWIDTH-1:0]             rf_res_i,
  input  logic                          rf_we_i,
  input  logic                          rf_wstb_i,
  output logic                          ram_we_o,
  output logic [ADR_WIDTH-1:0]          ram_waddr_o,
  output logic [31:0]                   ram_wdata_o,
  output logic [ADR_WIDTH*RAM_RP-1:0]   ram_raddr_o,
  input  logic [32*RAM_RP-1:0]          ram_rdata_i
);

  localparam int N  = (NRP + RAM_RP - 1) / RAM_RP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, READY} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [5*NRP-1:0] rs_q, rs_d;
  logic [31:0]      wb_q, wb_d;

  logic          start;
  logic          busy;
  logic          commit;
  logic          cap_vld;
  logic [CW-1:0] cap_slot;

  // Rotate right by one chunk; the doubled word keeps BWIDTH=32 legal.
  function automatic logic [31:0] rot(input logic [31:0] r);
    logic [63:0] t;
    t = {r, r} >> BWIDTH;
    return t[31:0];
  endfunction

  assign start    = ((state_q == IDLE) || (state_q == READY)) && rf_rstb_i;
  assign busy     = (state_q == ISSUE) || (state_q == DRAIN);
  assign commit   = rf_wstb_i && (rf_rd_i != 5'd0);
  // Data for a slot arrives one cycle after its address, so capture lags issue by one.
  assign cap_vld  = ((state_q == ISSUE) && (cnt_q != '0)) || (state_q == DRAIN);
  assign cap_slot = (state_q == DRAIN) ? CW'(N - 1) : cnt_q - 1'b1;

  assign rf_rdy_o    = (state_q == READY);
  assign rf_busy_o   = busy;
  assign ram_we_o    = commit;
  assign ram_waddr_o = ADR_WIDTH'(rf_rd_i);
  assign ram_wdata_o = wb_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rs_d    = rs_q;
    case (state_q)
      IDLE, READY: begin
        if (rf_rstb_i) begin
          rs_d    = rf_rs_i;
          cnt_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (cnt_q == CW'(N - 1)) state_d = DRAIN;
        else                     cnt_d   = cnt_q + 1'b1;
      end
      DRAIN:   state_d = READY;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    logic [32+BWIDTH-1:0] t;
    wb_d = wb_q;
    t    = '0;
    if (rf_shft_i) begin
      t    = {(rf_we_i ? rf_res_i : wb_q[BWIDTH-1:0]), wb_q} >> BWIDTH;
      wb_d = t[31:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rs_q    <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rs_q    <= rs_d;
      wb_q    <= wb_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < RAM_RP; gi++) begin : g_raddr
      logic [ADR_WIDTH-1:0] raddr;
      always_comb begin
        raddr = '0;
        if (state_q == ISSUE) begin
          for (int k = 0; k < NRP; k++) begin
            if ((k % RAM_RP == gi) && (k / RAM_RP == int'(cnt_q)))
              raddr[4:0] = rs_q[5*k +: 5];
          end
        end
      end
      assign ram_raddr_o[gi*ADR_WIDTH +: ADR_WIDTH] = raddr;
    end

    for (gi = 0; gi < NRP; gi++) begin : g_port
      localparam int SLOT = gi / RAM_RP;
      localparam int RP   = gi % RAM_RP;

      logic [31:0] op_q, op_d;
      logic        fwd_q, fwd_d;
      logic [4:0]  rs_k, rs_new;

      assign rs_k   = rs_q[5*gi +: 5];
      assign rs_new = rf_rs_i[5*gi +: 5];

      // A commit to this port's source wins over RAM data, which is stale by then.
      always_comb begin
        op_d  = op_q;
        fwd_d = fwd_q;
        if (start) begin
          fwd_d = 1'b0;
          if (rf_shft_i) op_d = rot(op_q);
          if (commit && (rf_rd_i == rs_new)) begin
            op_d  = wb_q;
            fwd_d = 1'b1;
          end
        end else if (busy) begin
          if (commit && (rf_rd_i == rs_k)) begin
            op_d  = wb_q;
            fwd_d = 1'b1;
          end else if (cap_vld && (int'(cap_slot) == SLOT) && !fwd_q) begin
            op_d = (rs_k == 5'd0) ? 32'h0 : ram_rdata_i[32*RP +: 32];
          end
        end else if (rf_shft_i) begin
          op_d = rot(op_q);
        end
      end

      always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
          op_q  <= '0;
          fwd_q <= 1'b0;
        end else begin
          op_q  <= op_d;
          fwd_q <= fwd_d;
        end
      end

      assign rf_op_o[gi*BWIDTH +: BWIDTH] = op_q[BWIDTH-1:0];
    end
  endgenerate

endmodule

// File: tb/tb_fazyrv_rf_mp.sv
// Bench for fazyrv_rf_mp: two instances (BWIDTH=4/1 RAM port, BWIDTH=1/2 RAM ports)
// with behavioural BRAMs; expected operand words are queued at the strobe and checked on readout.
module tb_fazyrv_rf_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // shared preload path into both RAM models
  logic        pre;
  logic [4:0]  pre_adr;
  logic [31:0] pre_dat;

  // instance A: BWIDTH=4, NRP=2, RAM_RP=1
  logic        a_rstb, a_rdy, a_busy, a_shft, a_we, a_wstb, a_ram_we;
  logic [9:0]  a_rs;
  logic [7:0]  a_op;
  logic [4:0]  a_rd, a_waddr, a_raddr;
  logic [3:0]  a_res;
  logic [31:0] a_wdata, a_rdata;
  logic [31:0] mem_a [32];

  // instance B: BWIDTH=1, NRP=2, RAM_RP=2
  logic        b_rstb, b_rdy, b_busy, b_shft, b_we, b_wstb, b_ram_we;
  logic [9:0]  b_rs;
  logic [1:0]  b_op;
  logic [4:0]  b_rd, b_waddr;
  logic [0:0]  b_res;
  logic [31:0] b_wdata;
  logic [9:0]  b_raddr;
  logic [63:0] b_rdata;
  logic [31:0] mem_b [32];

  fazyrv_rf_mp #(.BWIDTH(4), .NRP(2), .RAM_RP(1), .ADR_WIDTH(5)) dut_a (
    .clk_i(clk), .rst_in(rst_n), .rf_rstb_i(a_rstb), .rf_rs_i(a_rs),
    .rf_rdy_o(a_rdy), .rf_busy_o(a_busy), .rf_shft_i(a_shft), .rf_op_o(a_op),
    .rf_rd_i(a_rd), .rf_res_i(a_res), .rf_we_i(a_we), .rf_wstb_i(a_wstb),
    .ram_we_o(a_ram_we), .ram_waddr_o(a_waddr), .ram_wdata_o(a_wdata),
    .ram_raddr_o(a_raddr), .ram_rdata_i(a_rdata)
  );

  fazyrv_rf_mp #(.BWIDTH(1), .NRP(2), .RAM_RP(2), .ADR_WIDTH(5)) dut_b (
    .clk_i(clk), .rst_in(rst_n), .rf_rstb_i(b_rstb), .rf_rs_i(b_rs),
    .rf_rdy_o(b_rdy), .rf_busy_o(b_busy), .rf_shft_i(b_shft), .rf_op_o(b_op),
    .rf_rd_i(b_rd), .rf_res_i(b_res), .rf_we_i(b_we), .rf_wstb_i(b_wstb),
    .ram_we_o(b_ram_we), .ram_waddr_o(b_waddr), .ram_wdata_o(b_wdata),
    .ram_raddr_o(b_raddr), .ram_rdata_i(b_rdata)
  );

  always @(posedge clk) begin
    if (pre)           mem_a[pre_adr] <= pre_dat;
    else if (a_ram_we) mem_a[a_waddr] <= a_wdata;
    a_rdata <= mem_a[a_raddr];
  end

  always @(posedge clk) begin
    if (pre)           mem_b[pre_adr] <= pre_dat;
    else if (b_ram_we) mem_b[b_waddr] <= b_wdata;
    b_rdata[31:0]  <= mem_b[b_raddr[4:0]];
    b_rdata[63:32] <= mem_b[b_raddr[9:5]];
  end

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] sb_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic sb_pop_check(input string tag, input logic [31:0] got);
    if (sb_q.size() == 0) check({tag, "_sb_empty"}, got, ~got);
    else check(tag, got, sb_q.pop_front());
  endtask

  task automatic preload(input logic [4:0] adr, input logic [31:0] dat);
    pre = 1'b1; pre_adr = adr; pre_dat = dat;
    tick();
    pre = 1'b0;
  endtask

  // leaves the bench at the falling edge right after the strobe edge E0
  task automatic a_strobe(input logic [4:0] rs0, input logic [4:0] rs1);
    a_rs = {rs1, rs0}; a_rstb = 1'b1;
    tick();
    a_rstb = 1'b0;
  endtask

  task automatic a_wait_rdy(input int start, output int lat);
    lat = start;
    while (!a_rdy && lat < 12) begin
      tick();
      lat++;
    end
  endtask

  task automatic a_read(input string tag);
    logic [31:0] w0, w1;
    logic [7:0]  first;
    w0 = '0; w1 = '0;
    first = a_op;
    for (int i = 0; i < 8; i++) begin
      w0[4*i +: 4] = a_op[3:0];
      w1[4*i +: 4] = a_op[7:4];
      a_shft = 1'b1;
      tick();
    end
    a_shft = 1'b0;
    sb_pop_check({tag, "_p0"}, w0);
    sb_pop_check({tag, "_p1"}, w1);
    check({tag, "_rot32"}, {24'h0, a_op}, {24'h0, first});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [31:0] v, w0, w1;
    rst_n = 1'b0; pre = 1'b0; pre_adr = '0; pre_dat = '0;
    a_rstb = 0; a_rs = '0; a_shft = 0; a_rd = '0; a_res = '0; a_we = 0; a_wstb = 0;
    b_rstb = 0; b_rs = '0; b_shft = 0; b_rd = '0; b_res = '0; b_we = 0; b_wstb = 0;
    tick(); tick();
    check("rst_rdy",   {31'h0, a_rdy},    32'h0);
    check("rst_busy",  {31'h0, a_busy},   32'h0);
    check("rst_op",    {24'h0, a_op},     32'h0);
    check("rst_raddr", {27'h0, a_raddr},  32'h0);
    check("rst_we",    {31'h0, a_ram_we}, 32'h0);
    check("rst_wdata", a_wdata,           32'h0);
    rst_n = 1'b1;
    tick();
    preload(5'd5, 32'h12345678);
    preload(5'd6, 32'hCAFEBABE);
    preload(5'd0, 32'hFFFFFFFF);

    // basic read, one RAM port
    sb_q.push_back(32'h12345678); sb_q.push_back(32'hCAFEBABE);
    a_strobe(5'd5, 5'd6);
    check("a_busy_issue", {31'h0, a_busy}, 32'h1);
    check("a_raddr_s0", {27'h0, a_raddr}, 32'd5);
    a_wait_rdy(0, lat);
    check("a_lat", lat, 3);
    check("a_first_chunks", {24'h0, a_op}, 32'h000000E8);
    a_read("basic");

    // hazard: commit to rs1 source in the first ISSUE cycle
    v = 32'hDEADBEEF;
    for (int i = 0; i < 8; i++) begin
      a_res = v[4*i +: 4]; a_we = 1'b1; a_shft = 1'b1;
      tick();
    end
    a_we = 1'b0; a_shft = 1'b0;
    sb_q.push_back(32'hDEADBEEF); sb_q.push_back(32'hCAFEBABE);
    a_strobe(5'd5, 5'd6);
    a_wstb = 1'b1; a_rd = 5'd5;
    #1;
    check("haz_we",    {31'h0, a_ram_we}, 32'h1);
    check("haz_wdata", a_wdata, 32'hDEADBEEF);
    tick();
    a_wstb = 1'b0;
    a_wait_rdy(1, lat);
    check("haz_lat", lat, 3);
    a_read("haz");
    check("haz_ram5", mem_a[5], 32'hDEADBEEF);

    // x0 reads zero despite RAM word 0, rd=0 commit dropped
    sb_q.push_back(32'h0); sb_q.push_back(32'h0);
    a_strobe(5'd0, 5'd0);
    a_wait_rdy(0, lat);
    check("x0_lat", lat, 3);
    a_read("x0");
    a_wstb = 1'b1; a_rd = 5'd0;
    #1;
    check("rd0_we", {31'h0, a_ram_we}, 32'h0);
    tick();
    a_wstb = 1'b0;

    // strobe during busy ignored
    sb_q.push_back(32'hCAFEBABE); sb_q.push_back(32'hDEADBEEF);
    a_strobe(5'd6, 5'd5);
    a_rs = 10'h0; a_rstb = 1'b1;
    tick();
    a_rstb = 1'b0;
    a_wait_rdy(1, lat);
    check("busy_rstb_lat", lat, 3);
    a_read("busy_rstb");

    // asynchronous reset in the middle of ISSUE
    a_strobe(5'd5, 5'd6);
    check("mid_busy", {31'h0, a_busy}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy",  {31'h0, a_busy},  32'h0);
    check("mid_rst_rdy",   {31'h0, a_rdy},   32'h0);
    check("mid_rst_op",    {24'h0, a_op},    32'h0);
    check("mid_rst_raddr", {27'h0, a_raddr}, 32'h0);
    check("mid_rst_wdata", a_wdata,          32'h0);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    check("post_rst_busy", {31'h0, a_busy}, 32'h0);

    // instance B: two RAM ports, one-bit chunks
    sb_q.push_back(32'h12345678); sb_q.push_back(32'hCAFEBABE);
    b_rs = {5'd6, 5'd5}; b_rstb = 1'b1;
    tick();
    b_rstb = 1'b0;
    check("b_raddr", {22'h0, b_raddr}, {22'h0, 5'd6, 5'd5});
    lat = 0;
    while (!b_rdy && lat < 12) begin
      tick();
      lat++;
    end
    check("b_lat", lat, 2);
    w0 = '0; w1 = '0;
    for (int i = 0; i < 32; i++) begin
      w0[i] = b_op[0];
      w1[i] = b_op[1];
      b_shft = 1'b1;
      tick();
    end
    b_shft = 1'b0;
    sb_pop_check("b_p0", w0);
    sb_pop_check("b_p1", w1);

    // write buffer: 32 bits LSB-first then commit
    v = 32'hA5A5A5A5;
    for (int i = 0; i < 32; i++) begin
      b_res = v[i +: 1]; b_we = 1'b1; b_shft = 1'b1;
      tick();
    end
    b_we = 1'b0; b_shft = 1'b0;
    b_wstb = 1'b1; b_rd = 5'd7;
    #1;
    check("wb_wdata", b_wdata, 32'hA5A5A5A5);
    check("wb_waddr", {27'h0, b_waddr}, 32'd7);
    check("wb_we",    {31'h0, b_ram_we}, 32'h1);
    tick();
    b_wstb = 1'b0;
    check("wb_ram7", mem_b[7], 32'hA5A5A5A5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
